// File: rtl/wb_initiator.sv
// wb_initiator: single-transfer Wishbone classic master driven by valid/ready command and response ports
module wb_initiator #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic [7:0]  to_count
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state;
  logic [15:0] timer;
  assign cmd_ready = state == IDLE;
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= IDLE;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      busy      <= 1'b0;
      to_count  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          wbm_adr_o <= cmd_adr;
          wbm_dat_o <= cmd_dat;
          wbm_sel_o <= cmd_sel;
          wbm_we_o  <= cmd_we;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          timer     <= '0;
          busy      <= 1'b1;
          state     <= BUS;
        end
        BUS: if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else if (timer == 16'(TIMEOUT - 1)) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          rsp_dat   <= ERR_DATA;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
          to_count  <= to_count == 8'hFF ? to_count : to_count + 8'd1;
          state     <= RESP;
        end else begin
          timer <= timer + 16'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: timeline model of each transfer checked against the DUT on every falling edge
module tb_wb_initiator;
  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;
  logic        wb_clk = 1'b0, wb_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0, wbm_ack_i = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0, wbm_dat_i = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_ready, rsp_valid, rsp_err, wbm_we_o, wbm_cyc_o, wbm_stb_o, busy;
  logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [7:0]  to_count;
  int vecs = 0, errs = 0, stb_cnt = 0;
  bit on = 0;
  logic        exp_busy = 0, exp_cyc = 0, exp_we = 0, exp_rspv = 0, exp_err = 0;
  logic [31:0] exp_adr = 0, exp_dat = 0, exp_rdat = 0, last_dat = 0;
  logic [3:0]  exp_sel = 0;
  int          exp_to = 0;
  logic        last_err = 0;

  wb_initiator #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .to_count(to_count)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  always @(negedge wb_clk) if (on) begin
    chk("cmd_ready", cmd_ready, !exp_busy);
    chk("busy", busy, exp_busy);
    chk("cyc", wbm_cyc_o, exp_cyc);
    chk("stb", wbm_stb_o, exp_cyc);
    chk("rsp_valid", rsp_valid, exp_rspv);
    chk("to_count", to_count, exp_to);
    if (exp_cyc) begin
      chk("adr", wbm_adr_o, exp_adr);
      chk("wdat", wbm_dat_o, exp_dat);
      chk("sel", wbm_sel_o, exp_sel);
      chk("we", wbm_we_o, exp_we);
    end
    if (exp_rspv) begin
      chk("rsp_dat", rsp_dat, exp_rdat);
      chk("rsp_err", rsp_err, exp_err);
      last_dat = rsp_dat;
      last_err = rsp_err;
    end
    if (wbm_stb_o) stb_cnt++;
  end

  task automatic reset_model();
    exp_busy = 0; exp_cyc = 0; exp_rspv = 0; exp_to = 0;
  endtask

  task automatic do_reset();
    wb_rst = 1; cmd_valid = 0; wbm_ack_i = 0; rsp_ready = 0;
    tick();
    reset_model();
    wb_rst = 0;
    on = 1;
  endtask

  task automatic start_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    rsp_ready = 1'($urandom);
    stb_cnt = 0;
    tick();
    exp_busy = 1; exp_cyc = 1; exp_adr = adr; exp_dat = dat; exp_sel = sel; exp_we = we;
    cmd_valid = 1'($urandom); cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
    cmd_sel = 4'($urandom);
  endtask

  // Slave acks after w wait states; w >= T means it never acks.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input int w, input logic [31:0] rd, input int stall);
    bit hit;
    int l;
    hit = w < T;
    l = hit ? w + 1 : T;
    start_cmd(we, adr, dat, sel);
    for (int a = 0; a < l; a++) begin
      wbm_ack_i = (a == w);
      wbm_dat_i = (a == w) ? rd : $urandom;
      tick();
    end
    exp_cyc = 0; exp_rspv = 1; exp_err = !hit;
    exp_rdat = !hit ? ERR : (we ? 32'h0 : rd);
    if (!hit && exp_to < 255) exp_to++;
    wbm_ack_i = 0;
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 0; cmd_valid = 1'($urandom); wbm_ack_i = 1'($urandom); wbm_dat_i = $urandom;
      tick();
    end
    rsp_ready = 1;
    tick();
    exp_rspv = 0; exp_busy = 0;
    cmd_valid = 0; rsp_ready = 0; wbm_ack_i = 1'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_we", wbm_we_o, 0);
    xfer(1, 32'h3001_0004, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 0);
    chk("zw_stb_cycles", stb_cnt, 1);
    chk("zw_rsp_dat", last_dat, 0);
    xfer(0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 0);
    chk("w3_stb_cycles", stb_cnt, 4);
    chk("w3_rsp_dat", last_dat, 32'hCAFE_F00D);
    xfer(0, 32'h3000_0020, 32'h0, 4'hF, 1000, 32'h0, 4);
    chk("to_stb_cycles", stb_cnt, 16);
    chk("to_rsp_dat", last_dat, 32'hFFFF_FFFF);
    chk("to_rsp_err", last_err, 1);
    chk("to_count_1", to_count, 1);
    xfer(0, 32'h3000_0030, 32'h0, 4'h3, 2, 32'h1234_5678, 10);
    chk("bp_rsp_dat", last_dat, 32'h1234_5678);
    xfer(0, 32'h3000_0040, 32'h0, 4'hF, T - 1, 32'hBEEF_0001, 0);
    chk("edge_stb_cycles", stb_cnt, 16);
    chk("edge_rsp_err", last_err, 0);
    chk("edge_rsp_dat", last_dat, 32'hBEEF_0001);
    chk("edge_to_count", to_count, 1);
    start_cmd(0, 32'h3000_0050, 32'h0, 4'hF);
    wbm_ack_i = 0;
    tick();
    tick();
    wb_rst = 1;
    tick();
    reset_model();
    wb_rst = 0; cmd_valid = 0;
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_to_count", to_count, 0);
    xfer(0, 32'h3000_0060, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, 1);
    chk("post_rst_rsp_dat", last_dat, 32'h0BAD_CAFE);
    for (int n = 0; n < 200; n++)
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, T + 3), $urandom,
           $urandom_range(0, 4));
    for (int n = 0; n < 260; n++)
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), T + 5, $urandom, 0);
    chk("to_count_sat", to_count, 255);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic single-transfer initiator: the master end of the bus that the team's address-decoding bus splitter responds to.
- Accepts one read or write command at a time on a valid/ready command port and runs one Wishbone cycle (cyc/stb until ack).
- Returns read data or a timeout error on a valid/ready response port.
- Intended to let a local controller (UART bridge, test sequencer) drive the user-project Wishbone fabric.

Parameters:
- TIMEOUT, 64, bus cycles stb may stay asserted without ack before the transfer is aborted (legal range 2..65535).
- ERR_DATA, 32'hFFFF_FFFF, value returned on rsp_dat for a timed-out transfer.

Ports:
- wb_clk in 1 system clock; all logic on rising edge
- wb_rst in 1 synchronous active-high reset
- cmd_valid in 1 command offered
- cmd_ready out 1 command can be accepted
- cmd_we in 1 1=write, 0=read
- cmd_adr in 32 byte address
- cmd_dat in 32 write data
- cmd_sel in 4 byte selects
- rsp_valid out 1 response available
- rsp_ready in 1 response consumed
- rsp_dat out 32 read data (0 for writes, ERR_DATA on timeout)
- rsp_err out 1 transfer timed out
- wbm_adr_o out 32 bus address
- wbm_dat_o out 32 bus write data
- wbm_dat_i in 32 bus read data
- wbm_we_o out 1 bus write enable
- wbm_sel_o out 4 bus byte selects
- wbm_cyc_o out 1 bus cycle
- wbm_stb_o out 1 bus strobe
- wbm_ack_i in 1 bus acknowledge; may be combinational from stb
- busy out 1 state != IDLE
- to_count out 8 saturating count of timeouts since reset

Behaviour:
- Clock and reset: one clock, wb_clk; reset is wb_rst, synchronous and active-high.
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_dat=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=0, wbm_sel_o=0, busy=0, to_count=0, timer=0.
- All wbm_* outputs, rsp_* outputs and busy are registered. cmd_ready = (state==IDLE), combinational from state.
- FSM: IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - on the edge where cmd_valid & cmd_ready: latch adr/dat/sel/we onto wbm_* outputs, set cyc=stb=1, clear timer, go BUS.
  - wbm_ack_i is ignored.
- BUS, sampled each edge with stb=1:
  - wbm_ack_i=1: cyc=stb=0, we=0; rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err=0; rsp_valid=1; go RESP.
  - else if timer==TIMEOUT-1: cyc=stb=0; rsp_dat=ERR_DATA; rsp_err=1; rsp_valid=1; to_count += 1, saturating at 255; go RESP.
  - else timer += 1.
  - Ack has priority over timeout when both occur on the same edge.
- Timing results:
  - A zero-wait slave (ack same cycle as stb) yields stb high for exactly 1 cycle.
  - A slave that never acks yields stb high for exactly TIMEOUT cycles.
  - wbm_adr_o/dat_o/sel_o stay stable for the whole time cyc is high.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held stable until rsp_ready=1 at an edge; then rsp_valid=0 and go IDLE.
  - If rsp_ready is already high on entry, the response completes one cycle after rsp_valid rises.
  - A new command is accepted no earlier than the cycle after the response handshake.
  - wbm_ack_i is ignored (a stray late ack after timeout must not create a second response).
- Latency: command accept edge N -> cyc/stb high from N+1; ack edge M -> rsp_valid high from M+1. Minimum command-to-response is 2 cycles.
- Reset mid-operation: wb_rst in BUS or RESP drops cyc/stb and rsp_valid at that edge and returns all registers to their reset values. to_count clears.
- Command input: cmd_* are don't-care when cmd_valid=0; cmd_valid is not required to stay high while cmd_ready=0.

Test Plan:
- Write, zero-wait slave: cmd adr=0x3001_0004, dat=0xA5A5_1234, sel=4'hF, we=1 -> one cycle with cyc=stb=we=1 and those values on the bus; rsp_valid next cycle with rsp_dat=0, rsp_err=0.
- Read, 3-wait slave returning 0xCAFE_F00D -> stb high exactly 4 cycles; rsp_dat=0xCAFE_F00D, rsp_err=0; cmd_ready=0 throughout.
- Timeout, TIMEOUT=16, slave never acks -> stb high exactly 16 cycles; rsp_err=1, rsp_dat=0xFFFF_FFFF, to_count=1. A stray ack 2 cycles later produces no second response.
- Backpressure: rsp_ready held low 10 cycles after a read -> rsp_valid and rsp_dat stable for all 10; cmd_valid offered meanwhile is not accepted until the cycle after rsp_ready=1.
- Ack and timeout on the same edge (ack exactly at cycle TIMEOUT) -> rsp_err=0, correct read data, to_count unchanged.
- wb_rst asserted during BUS with cyc high -> cyc/stb=0 and busy=0 after that edge, to_count=0; the next command completes normally.
